// File: rtl/cap_xfer_seq.sv
// cap_xfer_seq: expands one opclass-4 capability load/store into a 10-word record of memory beats.
// Build option AMBER_CAP_RSV_CHECK_EN clears the loaded tag when reserved record bits are non-zero.
module cap_xfer_seq #(
    parameter int ADDR_W    = 24,
    parameter int REC_WORDS = 10
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic              iw_req_valid,
    output logic              ow_req_ready,
    input  logic              iw_req_store,
    input  logic [ADDR_W-1:0] iw_req_addr,
    input  logic [1:0]        iw_req_cr_idx,
    input  logic [47:0]       iw_win_base,
    input  logic [47:0]       iw_win_len,
    input  logic [47:0]       iw_src_base,
    input  logic [47:0]       iw_src_len,
    input  logic [47:0]       iw_src_cur,
    input  logic [23:0]       iw_src_perms,
    input  logic [23:0]       iw_src_attr,
    input  logic              iw_src_tag,
    input  logic              iw_flush,
    output logic              ow_busy,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic              ow_mem_re,
    output logic              ow_mem_we,
    output logic [23:0]       ow_mem_wdata,
    input  logic [23:0]       iw_mem_rdata,
    output logic              ow_cr_we,
    output logic [1:0]        ow_cr_idx,
    output logic [47:0]       ow_cap_base,
    output logic [47:0]       ow_cap_len,
    output logic [47:0]       ow_cap_cur,
    output logic [23:0]       ow_cap_perms,
    output logic [23:0]       ow_cap_attr,
    output logic              ow_cap_tag,
    output logic              ow_done,
    output logic              ow_fault
);

    typedef enum logic [2:0] {IDLE, LD, LD_TAIL, ST, DONE, FAULT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          beat_q;
    logic                last_beat, accept, oob;
    logic [48:0]         rec_lo, rec_hi, win_lo, win_hi;
    logic                st_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          idx_q;
    logic [47:0]         src_base_q, src_len_q, src_cur_q;
    logic [23:0]         src_perms_q, src_attr_q;
    logic                src_tag_q;
    logic [23:0]         st_word;
    logic [7:0][23:0]    ld_w_q;
    logic                w8_tag_q;
`ifdef AMBER_CAP_RSV_CHECK_EN
    logic                w8_rsv_q;
`endif

    assign last_beat = beat_q == 4'(REC_WORDS - 1);
    assign accept    = iw_req_valid & ow_req_ready;

    // Window check in 49 bits so base + len and addr + 10 cannot wrap
    always_comb begin
        rec_lo = 49'(iw_req_addr);
        rec_hi = rec_lo + 49'(REC_WORDS);
        win_lo = {1'b0, iw_win_base};
        win_hi = win_lo + {1'b0, iw_win_len};
        oob    = (rec_lo < win_lo) || (rec_hi > win_hi);
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= ((state_q == LD || state_q == ST) && state_d == state_q) ? beat_q + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (oob ? FAULT : (iw_req_store ? ST : LD)) : IDLE;
            LD:      state_d = last_beat ? LD_TAIL : LD;
            LD_TAIL: state_d = DONE;
            ST:      state_d = last_beat ? DONE : ST;
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (iw_flush && state_q != IDLE)
            state_d = IDLE;
    end

    always_comb begin
        case (beat_q)
            4'd0:    st_word = src_base_q[23:0];
            4'd1:    st_word = src_base_q[47:24];
            4'd2:    st_word = src_len_q[23:0];
            4'd3:    st_word = src_len_q[47:24];
            4'd4:    st_word = src_cur_q[23:0];
            4'd5:    st_word = src_cur_q[47:24];
            4'd6:    st_word = src_perms_q;
            4'd7:    st_word = src_attr_q;
            4'd8:    st_word = {23'd0, src_tag_q};
            default: st_word = '0;
        endcase
    end

    // A flush in the current cycle suppresses that cycle's strobes and pulses
    always_comb begin
        ow_req_ready = (state_q == IDLE) & ~iw_flush;
        ow_busy      = state_q != IDLE;
        ow_mem_re    = (state_q == LD) & ~iw_flush;
        ow_mem_we    = (state_q == ST) & ~iw_flush;
        ow_mem_addr  = (state_q == LD || state_q == ST) ? addr_q + ADDR_W'(beat_q) : '0;
        ow_mem_wdata = ow_mem_we ? st_word : '0;
        ow_done      = (state_q == DONE) & ~iw_flush;
        ow_cr_we     = ow_done & ~st_q;
        ow_cr_idx    = ow_cr_we ? idx_q : 2'd0;
        ow_fault     = (state_q == FAULT) & ~iw_flush;
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            st_q        <= 1'b0;
            addr_q      <= '0;
            idx_q       <= '0;
            src_base_q  <= '0;
            src_len_q   <= '0;
            src_cur_q   <= '0;
            src_perms_q <= '0;
            src_attr_q  <= '0;
            src_tag_q   <= 1'b0;
        end else if (accept) begin
            st_q        <= iw_req_store;
            addr_q      <= iw_req_addr;
            idx_q       <= iw_req_cr_idx;
            src_base_q  <= iw_src_base;
            src_len_q   <= iw_src_len;
            src_cur_q   <= iw_src_cur;
            src_perms_q <= iw_src_perms;
            src_attr_q  <= iw_src_attr;
            src_tag_q   <= iw_src_tag;
        end
    end

    // Words 0..7 shift into a staging line; word 8 keeps only tag/reserved info; word 9 is consumed live in LD_TAIL
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ld_w_q       <= '0;
            w8_tag_q     <= 1'b0;
`ifdef AMBER_CAP_RSV_CHECK_EN
            w8_rsv_q     <= 1'b0;
`endif
            ow_cap_base  <= '0;
            ow_cap_len   <= '0;
            ow_cap_cur   <= '0;
            ow_cap_perms <= '0;
            ow_cap_attr  <= '0;
            ow_cap_tag   <= 1'b0;
        end else begin
            if (state_q == LD && beat_q != 4'd0) begin
                if (last_beat) begin
                    w8_tag_q <= iw_mem_rdata[0];
`ifdef AMBER_CAP_RSV_CHECK_EN
                    w8_rsv_q <= |iw_mem_rdata[23:1];
`endif
                end else begin
                    ld_w_q <= {iw_mem_rdata, ld_w_q[7:1]};
                end
            end
            if (state_q == LD_TAIL && !iw_flush) begin
                ow_cap_base  <= {ld_w_q[1], ld_w_q[0]};
                ow_cap_len   <= {ld_w_q[3], ld_w_q[2]};
                ow_cap_cur   <= {ld_w_q[5], ld_w_q[4]};
                ow_cap_perms <= ld_w_q[6];
                ow_cap_attr  <= ld_w_q[7];
`ifdef AMBER_CAP_RSV_CHECK_EN
                ow_cap_tag   <= w8_tag_q & ~w8_rsv_q & ~|iw_mem_rdata;
`else
                ow_cap_tag   <= w8_tag_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cap_xfer_seq.sv
// tb_cap_xfer_seq: table-driven capability transfer vectors with a completion scoreboard,
// plus flush, back-to-back and mid-transfer reset sequences.
module tb_cap_xfer_seq;

    typedef struct {
        logic        st;
        logic [23:0] addr;
        logic [1:0]  idx;
        logic [47:0] wb, wl, b, l, c;
        logic [23:0] p, a;
        logic        t;
        logic [22:0] w8hi;
        logic [23:0] w9;
        logic        flt;
    } txn_t;

    typedef struct {
        logic        fault, ld;
        logic [1:0]  idx;
        logic [47:0] b, l, c;
        logic [23:0] p, a;
        logic        tag;
    } exp_t;

    logic        iw_clk = 1'b0, iw_rst = 1'b1;
    logic        iw_req_valid = 1'b0, iw_req_store = 1'b0, iw_flush = 1'b0, iw_src_tag = 1'b0;
    logic [23:0] iw_req_addr = '0, iw_src_perms = '0, iw_src_attr = '0;
    logic [1:0]  iw_req_cr_idx = '0;
    logic [47:0] iw_win_base = '0, iw_win_len = '0, iw_src_base = '0, iw_src_len = '0, iw_src_cur = '0;
    logic        ow_req_ready, ow_busy, ow_mem_re, ow_mem_we, ow_cr_we, ow_cap_tag, ow_done, ow_fault;
    logic [23:0] ow_mem_addr, ow_mem_wdata, ow_cap_perms, ow_cap_attr, rdata;
    logic [1:0]  ow_cr_idx;
    logic [47:0] ow_cap_base, ow_cap_len, ow_cap_cur;

    logic [23:0] mem [0:1023];
    logic [23:0] img [0:1023];
    int          wcnt [0:1023];
    exp_t        sb[$];
    exp_t        mon_e;
    txn_t        tv[8];
    int          checks = 0, errors = 0;

    always #5 iw_clk = ~iw_clk;

    cap_xfer_seq dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_req_valid(iw_req_valid), .ow_req_ready(ow_req_ready),
        .iw_req_store(iw_req_store), .iw_req_addr(iw_req_addr), .iw_req_cr_idx(iw_req_cr_idx),
        .iw_win_base(iw_win_base), .iw_win_len(iw_win_len), .iw_src_base(iw_src_base),
        .iw_src_len(iw_src_len), .iw_src_cur(iw_src_cur), .iw_src_perms(iw_src_perms),
        .iw_src_attr(iw_src_attr), .iw_src_tag(iw_src_tag), .iw_flush(iw_flush), .ow_busy(ow_busy),
        .ow_mem_addr(ow_mem_addr), .ow_mem_re(ow_mem_re), .ow_mem_we(ow_mem_we),
        .ow_mem_wdata(ow_mem_wdata), .iw_mem_rdata(rdata), .ow_cr_we(ow_cr_we), .ow_cr_idx(ow_cr_idx),
        .ow_cap_base(ow_cap_base), .ow_cap_len(ow_cap_len), .ow_cap_cur(ow_cap_cur),
        .ow_cap_perms(ow_cap_perms), .ow_cap_attr(ow_cap_attr), .ow_cap_tag(ow_cap_tag),
        .ow_done(ow_done), .ow_fault(ow_fault)
    );

    // Data memory: stores land in mem, loads read the preloaded image one cycle later
    always @(posedge iw_clk) begin
        if (ow_mem_we) begin
            mem[ow_mem_addr[9:0]]  <= ow_mem_wdata;
            wcnt[ow_mem_addr[9:0]] <= wcnt[ow_mem_addr[9:0]] + 1;
        end
        rdata <= ow_mem_re ? img[ow_mem_addr[9:0]] : 24'h0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic st, input logic [23:0] addr, input logic [1:0] idx,
                                input logic [47:0] wb, wl, b, l, c, input logic [23:0] p, a,
                                input logic t, input logic [22:0] w8hi, input logic [23:0] w9,
                                input logic flt);
        txn_t r;
        r.st = st; r.addr = addr; r.idx = idx; r.wb = wb; r.wl = wl; r.b = b; r.l = l; r.c = c;
        r.p = p; r.a = a; r.t = t; r.w8hi = w8hi; r.w9 = w9; r.flt = flt;
        return r;
    endfunction

    function automatic logic [23:0] rec_word(input txn_t t, input int k);
        case (k)
            0: return t.b[23:0];
            1: return t.b[47:24];
            2: return t.l[23:0];
            3: return t.l[47:24];
            4: return t.c[23:0];
            5: return t.c[47:24];
            6: return t.p;
            7: return t.a;
            8: return {t.w8hi, t.t};
            default: return t.w9;
        endcase
    endfunction

    function automatic exp_t to_exp(input txn_t t);
        exp_t e;
        e.fault = t.flt; e.ld = !t.st; e.idx = t.idx;
        e.b = t.b; e.l = t.l; e.c = t.c; e.p = t.p; e.a = t.a;
`ifdef AMBER_CAP_RSV_CHECK_EN
        e.tag = t.t && t.w9 == 24'h0 && t.w8hi == 23'h0;
`else
        e.tag = t.t;
`endif
        return e;
    endfunction

    task automatic drive(input txn_t t);
        iw_req_store = t.st; iw_req_addr = t.addr; iw_req_cr_idx = t.idx;
        iw_win_base = t.wb; iw_win_len = t.wl;
        iw_src_base = t.b; iw_src_len = t.l; iw_src_cur = t.c;
        iw_src_perms = t.p; iw_src_attr = t.a; iw_src_tag = t.t;
    endtask

    task automatic load_img(input txn_t t);
        logic [23:0] ad;
        for (int k = 0; k < 10; k++) begin
            ad = t.addr + 24'(k);
            img[ad[9:0]] = rec_word(t, k);
        end
    endtask

    task automatic check_store(input txn_t t);
        logic [23:0] ad;
        for (int k = 0; k < 10; k++) begin
            ad = t.addr + 24'(k);
            chk("st_word", mem[ad[9:0]], rec_word(t, k));
        end
    endtask

    // Scoreboard: every completion or fault pulse pops the oldest expected outcome
    always @(negedge iw_clk) begin
        if (!iw_rst && (ow_done || ow_fault || ow_cr_we)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: done=%0b fault=%0b cr_we=%0b with nothing expected", ow_done, ow_fault, ow_cr_we);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_fault", ow_fault, mon_e.fault);
                chk("sb_done", ow_done, !mon_e.fault);
                chk("sb_cr_we", ow_cr_we, mon_e.ld && !mon_e.fault);
                if (mon_e.ld && !mon_e.fault) begin
                    chk("sb_idx", ow_cr_idx, mon_e.idx);
                    chk("sb_base", ow_cap_base, mon_e.b);
                    chk("sb_len", ow_cap_len, mon_e.l);
                    chk("sb_cur", ow_cap_cur, mon_e.c);
                    chk("sb_perms", ow_cap_perms, mon_e.p);
                    chk("sb_attr", ow_cap_attr, mon_e.a);
                    chk("sb_tag", ow_cap_tag, mon_e.tag);
                end
            end
        end
    end

    task automatic run(input txn_t t);
        int dc, w;
        logic xr, xw;
        if (!t.st) load_img(t);
        sb.push_back(to_exp(t));
        @(negedge iw_clk);
        drive(t);
        iw_req_valid = 1'b1;
        w = 0;
        while (!ow_req_ready && w < 40) begin
            @(negedge iw_clk);
            w++;
        end
        if (w == 40) chk("accept_timeout", ow_req_ready, 1);
        @(posedge iw_clk);
        dc = t.flt ? 1 : (t.st ? 11 : 12);
        for (int n = 1; n <= dc + 1; n++) begin
            @(negedge iw_clk);
            if (n == 1) iw_req_valid = 1'b0;
            xr = !t.flt && !t.st && n <= 10;
            xw = !t.flt && t.st && n <= 10;
            chk("mem_re", ow_mem_re, xr);
            chk("mem_we", ow_mem_we, xw);
            if (xr || xw) chk("mem_addr", ow_mem_addr, t.addr + 24'(n - 1));
            if (xw) chk("mem_wdata", ow_mem_wdata, rec_word(t, n - 1));
            chk("done_time", ow_done, !t.flt && n == dc);
            chk("fault_time", ow_fault, t.flt && n == 1);
            if (n < dc || (t.flt && n == 1)) chk("busy", ow_busy, 1);
            else if (n == dc + 1) begin
                chk("idle_busy", ow_busy, 0);
                chk("idle_ready", ow_req_ready, 1);
            end
        end
        if (t.st && !t.flt) check_store(t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        txn_t fl, lds, sts;
        int   first_we, ovl;
        tv[0] = mk(1, 24'd107, 2'd0, 48'd100, 48'd32, 48'd4000, 48'd123, 48'd4010, 24'hA5A5, 24'h55AA, 1, 23'h0, 24'h0, 0);
        tv[1] = mk(0, 24'd300, 2'd1, 48'd300, 48'd64, 48'h005678001234, 48'h50, 48'h005678001240, 24'hF0, 24'hF, 1, 23'h0, 24'h0, 0);
        tv[2] = mk(1, 24'd125, 2'd0, 48'd100, 48'd32, 48'h1, 48'h2, 48'h3, 24'h4, 24'h5, 1, 23'h0, 24'h0, 1);
        tv[3] = mk(1, 24'd122, 2'd0, 48'd100, 48'd32, 48'hABCDEF123456, 48'h0, 48'hFFFFFF000001, 24'h800001, 24'h7FFFFE, 0, 23'h0, 24'h0, 0);
        tv[4] = mk(0, 24'd400, 2'd3, 48'd400, 48'd10, 48'h111111222222, 48'h333333444444, 48'h555555666666, 24'h777777, 24'h888888, 1, 23'h0, 24'h000001, 0);
        tv[5] = mk(0, 24'd420, 2'd2, 48'd410, 48'd20, 48'h0A0000000B, 48'hC, 48'hD0000000E, 24'h1F, 24'h2E, 1, 23'h1, 24'h0, 0);
        tv[6] = mk(0, 24'd99, 2'd1, 48'd100, 48'd32, 48'h1, 48'h2, 48'h3, 24'h4, 24'h5, 1, 23'h0, 24'h0, 1);
        tv[7] = mk(0, 24'd440, 2'd0, 48'd0, 48'h400000000000, 48'hFEDCBA987654, 48'h13579B, 48'h2468AC, 24'hFFFFFF, 24'h0, 0, 23'h0, 24'h0, 0);

        repeat (3) @(negedge iw_clk);
        chk("rst_ready", ow_req_ready, 1);
        chk("rst_busy", ow_busy, 0);
        chk("rst_re", ow_mem_re, 0);
        chk("rst_we", ow_mem_we, 0);
        chk("rst_done", ow_done, 0);
        chk("rst_fault", ow_fault, 0);
        chk("rst_cr_we", ow_cr_we, 0);
        chk("rst_cap_base", ow_cap_base, 0);
        chk("rst_mem_addr", ow_mem_addr, 0);
        iw_rst = 1'b0;

        for (int i = 0; i < 8; i++) run(tv[i]);

        // Flush in cycle 5 of a store: beats 0..3 written, nothing after, no completion
        fl = mk(1, 24'd500, 2'd0, 48'd500, 48'd20, 48'h0A0B0C0D0E0F, 48'h1, 48'h2000003, 24'h5, 24'h6, 1, 23'h0, 24'h0, 0);
        @(negedge iw_clk);
        drive(fl);
        iw_req_valid = 1'b1;
        chk("fl_ready", ow_req_ready, 1);
        @(posedge iw_clk);
        for (int n = 1; n <= 9; n++) begin
            @(negedge iw_clk);
            if (n == 1) iw_req_valid = 1'b0;
            chk("fl_we", ow_mem_we, n <= 5);
            chk("fl_no_done", ow_done | ow_cr_we | ow_fault, 0);
            if (n == 6) begin
                chk("fl_ready_after", ow_req_ready, 1);
                chk("fl_busy_after", ow_busy, 0);
            end
            if (n == 5) begin
                iw_flush = 1'b1;
                @(posedge iw_clk);
                #1 iw_flush = 1'b0;
            end
        end
        for (int k = 0; k < 10; k++) chk("fl_wcnt", wcnt[500 + k], k < 4 ? 1 : 0);

        // Back-to-back: load held valid, then a store held valid behind it
        lds = mk(0, 24'd600, 2'd2, 48'd0, 48'd1000, 48'h0C0FFEE0BEEF, 48'h42, 48'h0C0FFEE0BF00, 24'h3C3C3C, 24'h0F0F0F, 1, 23'h0, 24'h0, 0);
        sts = mk(1, 24'd700, 2'd0, 48'd0, 48'd1000, 48'h123456789ABC, 48'hDEF012, 48'h345678, 24'h9, 24'hA, 0, 23'h0, 24'h0, 0);
        load_img(lds);
        sb.push_back(to_exp(lds));
        sb.push_back(to_exp(sts));
        @(negedge iw_clk);
        drive(lds);
        iw_req_valid = 1'b1;
        @(posedge iw_clk);
        first_we = 0;
        ovl = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge iw_clk);
            if (n == 1) drive(sts);
            if (n == 14) iw_req_valid = 1'b0;
            if (ow_mem_re && ow_mem_we) ovl++;
            if (ow_mem_we && first_we == 0) first_we = n;
        end
        chk("b2b_first_we", first_we, 14);
        chk("b2b_overlap", ovl, 0);
        check_store(sts);
        chk("b2b_cap_kept", ow_cap_base, lds.b);

        // Reset in the middle of a store drops strobes at once and clears captured state
        @(negedge iw_clk);
        drive(tv[0]);
        iw_req_valid = 1'b1;
        @(posedge iw_clk);
        repeat (3) @(negedge iw_clk);
        iw_req_valid = 1'b0;
        chk("mid_we_before", ow_mem_we, 1);
        iw_rst = 1'b1;
        #1;
        chk("mid_rst_we", ow_mem_we, 0);
        chk("mid_rst_busy", ow_busy, 0);
        chk("mid_rst_ready", ow_req_ready, 1);
        chk("mid_rst_cap", ow_cap_base, 0);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        repeat (3) @(negedge iw_clk);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cap_xfer_seq.md
Name: cap_xfer_seq

Overview:
- Memory-access-stage sequencer for opclass-4 capability transfers (CLDcso, CSTcso) in the amber core.
- Accepts one request from EX/MA and expands it into the fixed 10-word capability record of 24-bit data-memory accesses.
- For loads, assembles the record and writes it to the target CR. For stores, serialises the source CR into memory.
- Holds the pipeline stall while active.

Parameters:
- ADDR_W, 24, data-memory word-address width.
- REC_WORDS, 10, words per capability record; fixed layout, must equal 10.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_req_valid  in  1  transfer request.
- ow_req_ready  out  1  high only in IDLE.
- iw_req_store  in  1  1 = CST, 0 = CLD.
- iw_req_addr  in  ADDR_W  record start address (authorising CR cur + imm, computed upstream).
- iw_req_cr_idx  in  2  CLD destination CR.
- iw_win_base  in  48  authorising CR base.
- iw_win_len  in  48  authorising CR length.
- iw_src_base, iw_src_len, iw_src_cur  in  48 each  CST source fields.
- iw_src_perms, iw_src_attr  in  24 each  CST source fields.
- iw_src_tag  in  1  CST source tag.
- iw_flush  in  1  abort current transfer.
- ow_busy  out  1  pipeline stall.
- ow_mem_addr  out  ADDR_W  data-memory address.
- ow_mem_re  out  1  read strobe.
- ow_mem_we  out  1  write strobe.
- ow_mem_wdata  out  24  write data.
- iw_mem_rdata  in  24  read data, valid the cycle after ow_mem_re.
- ow_cr_we  out  1  one-cycle CR write pulse.
- ow_cr_idx  out  2  CR write index.
- ow_cap_base, ow_cap_len, ow_cap_cur  out  48 each  assembled fields.
- ow_cap_perms, ow_cap_attr  out  24 each  assembled fields.
- ow_cap_tag  out  1  assembled tag.
- ow_done  out  1  one-cycle completion pulse.
- ow_fault  out  1  one-cycle bounds-fault pulse.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0 except ow_req_ready = 1.
  - Capture registers cleared.
- Record layout, word k at addr+k:
  - 0 BASE[23:0], 1 BASE[47:24]
  - 2 LEN lo, 3 LEN hi
  - 4 CUR lo, 5 CUR hi
  - 6 PERMS, 7 ATTR
  - 8 TAG in bit 0, other bits 0
  - 9 reserved, written 0
- Accept: on a clock edge with iw_req_valid & ow_req_ready, all request fields are latched. The cycle of that edge is cycle 0.
- Bounds check in the accept cycle, computed in 49 bits with no wrap:
  - Fault if addr < win_base or addr + 10 > win_base + win_len.
  - On fault: state goes to FAULT, no memory access, ow_fault pulses in cycle 1, then IDLE.
- States:
  - IDLE -> LD or ST on accept.
  - LD -> LD_TAIL after beat 9.
  - LD_TAIL -> DONE.
  - ST -> DONE after beat 9.
  - DONE -> IDLE.
  - FAULT -> IDLE.
- Beat counter 0..9. Beat k occupies cycle k+1 with ow_mem_addr = addr+k.
- ST:
  - ow_mem_we = 1 on cycles 1..10, data per the layout.
  - ow_done pulses in cycle 11.
- LD:
  - ow_mem_re = 1 on cycles 1..10.
  - Word k is captured on cycle k+2.
  - Cycle 12: ow_done = ow_cr_we = 1, ow_cr_idx = latched index, ow_cap_* hold the assembled record.
  - ow_cap_tag = word8[0].
- ow_busy = 1 from cycle 1 through the cycle before DONE/FAULT returns to IDLE.
  - Total: ST 11 cycles, LD 12 cycles, fault 1 cycle.
- ow_cap_* are stable between completions and are not updated by stores.
- ow_req_ready = 0 in every non-IDLE state. A request presented while busy is held by the requester.
- iw_flush in any non-IDLE state:
  - Next state IDLE; no done, fault or cr_we.
  - Words already stored stay written; partial load data is discarded.
  - Flush in IDLE is ignored. Flush has priority over a simultaneous accept.
- Reset mid-transfer: immediate return to IDLE, all strobes 0 asynchronously.
- Address arithmetic addr+k wraps modulo 2^ADDR_W. This cannot occur for in-bounds requests.

Optional Feature:
- Macro AMBER_CAP_RSV_CHECK_EN.
- Defined: on load, if word9 != 0 or word8[23:1] != 0, ow_cap_tag is forced to 0. All other fields load normally and ow_cr_we still pulses.
- Undefined: word9 and word8[23:1] are ignored; tag = word8[0].

Test Plan:
- CST src base=4000 len=123 cur=4010 perms=A5A5 attr=55AA tag=1, addr=107, window [100,132) -> mem[107..116] = FA0,0,7B,0,FAA,0,00A5A5,0055AA,1,0; ow_done in cycle 11; ow_busy high cycles 1..10.
- CLD from addr 300 holding 1234,5678,50,0,1240,5678,F0,F,1,0, window [300,364), cr_idx=1 -> cycle 12 ow_cr_we=1, idx=1, base={5678,1234}, len=50, cur={5678,1240}, perms=F0, attr=F, tag=1.
- Bounds fault: addr=125, window [100,132) -> ow_fault in cycle 1, no re/we ever asserted, ready returns in cycle 2. Boundary addr=122 is accepted.
- iw_flush asserted in cycle 5 of a CST -> mem[addr..addr+3] written, addr+4.. untouched, no ow_done, ready=1 next cycle.
- Back-to-back: CLD held valid then CST held valid -> CST accepted on the first IDLE cycle after CLD's DONE; no overlap of strobes.
- With AMBER_CAP_RSV_CHECK_EN, word9 = 000001 -> ow_cap_tag = 0, other fields correct. Without the macro -> tag = 1.
